// File: rtl/aes_core_scheduler.sv
// aes_core_scheduler: round-robin sharing of one cipher core between NREQ requesters,
// one block in flight, with valid/ready request and response handshakes.
module aes_core_scheduler #(
    parameter int NREQ = 2,
    parameter int NK   = 4,
    localparam int LAT = (NK + 7) * 4 + 4,
    localparam int CW  = $clog2(LAT + 1),
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*128-1:0]   req_state,
    input  logic [NREQ*NK*32-1:0] req_key,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [127:0]          resp_data,
    output logic                  core_reset,
    output logic                  core_enable,
    output logic [127:0]          core_state_in,
    output logic [NK*32-1:0]      core_key,
    input  logic [127:0]          core_state_out,
    output logic                  busy
);
    localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, RUN = 3'd2, CAPTURE = 3'd3, DONE = 3'd4;
    logic [2:0]       state_q, state_d;
    logic [PW-1:0]    rr_q, rr_d, grant_q, grant_d, win, idx;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [127:0]     resp_q, resp_d, st_q, st_d;
    logic [NK*32-1:0] key_q, key_d;
    logic             found;

    // scan from farthest to nearest so the requester closest after rr_q wins
    always_comb begin
        win = rr_q;
        idx = rr_q;
        found = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = PW'((int'(rr_q) + i) % NREQ);
            if (req_valid[idx]) begin
                win = idx;
                found = 1'b1;
            end
        end
    end

    assign req_ready     = (!reset && state_q == IDLE && found) ? NREQ'(1) << win : '0;
    assign resp_valid    = (!reset && state_q == DONE) ? NREQ'(1) << grant_q : '0;
    assign resp_data     = resp_q;
    assign core_reset    = reset | (state_q == CLEAR);
    assign core_enable   = state_q == RUN;
    assign core_state_in = st_q;
    assign core_key      = key_q;
    assign busy          = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        rr_d = rr_q;
        grant_d = grant_q;
        cnt_d = cnt_q;
        resp_d = resp_q;
        st_d = st_q;
        key_d = key_q;
        case (state_q)
            IDLE: if (found) begin
                st_d = req_state[win*128 +: 128];
                key_d = req_key[win*NK*32 +: NK*32];
                grant_d = win;
                rr_d = win;
                state_d = CLEAR;
            end
            CLEAR: begin
                cnt_d = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(LAT - 1)) ? CAPTURE : RUN;
            end
            CAPTURE: begin
                resp_d = core_state_out;
                state_d = DONE;
            end
            DONE: state_d = resp_ready[grant_q] ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q <= PW'(NREQ - 1);
            grant_q <= '0;
            cnt_q <= '0;
            resp_q <= '0;
            st_q <= '0;
            key_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q <= rr_d;
            grant_q <= grant_d;
            cnt_q <= cnt_d;
            resp_q <= resp_d;
            st_q <= st_d;
            key_q <= key_d;
        end
    end
endmodule

// File: doc/aes_core_scheduler.md
Name: aes_core_scheduler

Overview:
- Shares one `cipher` encryption core between NREQ requesters using round-robin arbitration. Only one block is in flight at a time.
- For each accepted request it: latches plaintext and key, pulse-resets the core, drives the core's enable for the exact round-schedule length, captures the ciphertext, and returns it to the granted requester through a valid/ready response.
- Sits between the bus-side requesters and the cipher core instance; it owns all of the core's control inputs.

Parameters:
- NREQ, 2, number of requesters (2..8).
- NK, 4, key length in 32-bit words (4, 6 or 8); passed to the core's nk.
- LAT, (NK+7)*4+4, enabled core cycles per block: 48 / 56 / 64 for NK 4 / 6 / 8. Derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous active-high reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  request accept, one-hot or zero.
- req_state  in  NREQ*128  plaintext; requester k at [k*128 +: 128].
- req_key  in  NREQ*NK*32  cipher key; requester k at [k*NK*32 +: NK*32].
- resp_valid  out  NREQ  response valid, one-hot or zero.
- resp_ready  in  NREQ  response accept per requester.
- resp_data  out  128  ciphertext of the last completed block.
- core_reset  out  1  to core reset.
- core_enable  out  1  to core enable.
- core_state_in  out  128  to core state_in (registered).
- core_key  out  NK*32  to core initial_key (registered).
- core_state_out  in  128  from core state_out.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE, rr_ptr=NREQ-1 (so requester 0 wins first), grant=0, cnt=0, resp_data=0, core_state_in=0, core_key=0. All handshake outputs are 0 during reset.
- core_reset = reset OR (state==CLEAR). A reset in any state therefore also clears the core.
- FSM states: IDLE -> CLEAR -> RUN -> CAPTURE -> DONE -> IDLE.
- IDLE:
  - Winner = first requester with req_valid set, searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - req_ready[winner] = 1; all other req_ready bits = 0.
  - If no req_valid bit is set, req_ready = 0 and the FSM stays in IDLE.
  - On accept (req_valid[w] & req_ready[w]): latch req_state[w] -> core_state_in and req_key[w] -> core_key; grant=w; rr_ptr=w; go to CLEAR.
- CLEAR: one cycle; core_reset=1, core_enable=0; cnt=0; go to RUN.
- RUN:
  - core_enable=1 for exactly LAT consecutive cycles; cnt increments each cycle.
  - When cnt==LAT-1, go to CAPTURE.
  - core_state_in and core_key are held stable throughout RUN.
- CAPTURE: one cycle; core_enable=0; resp_data <= core_state_out; go to DONE.
- DONE:
  - resp_valid[grant]=1; resp_data is held stable.
  - On resp_ready[grant], go to IDLE. resp_ready bits of non-granted requesters are ignored.
  - No new request is granted until the FSM returns to IDLE. The earliest next accept is the cycle after the response handshake.
- req_ready is 0 in every state except IDLE.
- Latency: accept at edge E0 -> resp_valid first high in the cycle after edge E0+LAT+2. That is 50 / 58 / 66 cycles for NK 4 / 6 / 8.
- cnt width is clog2(LAT+1). No wrap-around occurs within a block.
- A request withdrawn (req_valid dropped) while not granted has no effect. The grant is decided only in IDLE, and only from that cycle's req_valid.
- resp_data keeps its last value after the handshake, until the next CAPTURE.
- Reset mid-operation: the in-flight block is discarded with no response. All outputs return to their reset values at the next edge. rr_ptr returns to NREQ-1.

Test Plan:
- Single request, NK=4: requester 0, key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff.
  - Required: resp_valid[0] rises exactly 50 cycles after accept, with resp_data=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: core_enable is high for exactly 48 cycles, and core_reset pulses once.
- Contention: req_valid=2'b11 straight after reset.
  - Required: requester 0 is served first, then requester 1 (ready asserted the cycle after resp0's handshake), with correct ciphertexts and one-hot resp_valid.
- Fairness: requester 0 held valid permanently; requester 1 raises valid during requester 0's RUN.
  - Required: the next grant goes to requester 1, not requester 0.
- Backpressure: resp_ready held low for 20 cycles in DONE.
  - Required: resp_valid stays high, resp_data is unchanged, req_ready stays 0, and busy stays 1.
- Reset mid-RUN: assert reset at cnt=20.
  - Required: at the next edge state=IDLE, busy=0, core_reset=1 during reset, and no resp_valid ever appears for that block.
  - Required: the next request then completes correctly.
- NK=8: key 000102...1e1f, plaintext 00112233445566778899aabbccddeeff.
  - Required: resp_data=8ea2b7ca516745bfeafc49904b496089, 66 cycles after accept.
